// File: rtl/intersection_cmd_driver_pkg.sv
// Shared definitions for the intersection command driver.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package intersection_cmd_driver_pkg;

   // Request op encoding; identical to the simulator's mode[1:0].
   localparam logic [1:0] OP_REMA = 2'b00;
   localparam logic [1:0] OP_REMB = 2'b01;
   localparam logic [1:0] OP_ADDA = 2'b10;
   localparam logic [1:0] OP_ADDB = 2'b11;

   localparam logic [2:0] MODE_DISPLAY = 3'b100;
   localparam logic [2:0] MODE_BLANK   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_GREEN,
      ST_SETUP,
      ST_FIRE,
      ST_RELEASE
   } state_t;

   function automatic logic is_add(input logic [1:0] op);
      return (op == OP_ADDA) || (op == OP_ADDB);
   endfunction

   // A remove may only be issued while its own road is green; adds never wait.
   function automatic logic road_green(input logic [1:0] op, input logic ga, input logic gb);
      logic g;
      case (op)
         OP_REMA: g = ga;
         OP_REMB: g = gb;
         default: g = 1'b1;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/intersection_cmd_driver_cmd_fifo.sv
// Synchronous request FIFO, DEPTH x W, head data read combinationally from rd_ptr.
// Latency: a pushed entry becomes visible on head_vld one cycle after its push edge (no bypass).
// Backpressure: push is ignored while full, even when a pop happens on the same edge.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_dat  write request and data
//   pop             remove head entry (ignored when empty)
//   head_dat        oldest entry
//   head_vld        head exists and was not written on the previous edge
//   full, empty     occupancy flags
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         head_vld,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_q;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   // With a single entry that was written on the last edge, the head is that
   // fresh entry: hold it back one cycle. With two or more entries the head is
   // always older than the last write.
   assign head_vld = !empty && !((count == ONE_CNT) && push_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         push_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count  <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
         push_q <= do_push;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/intersection_cmd_driver.sv
// Command front end for IntersectionSimulator: queues add/remove requests and replays them as clean action pulses.
// Latency: add into empty queue pushed at edge E -> mode/plateIn at E+2, action high for one cycle at E+3, pop at E+5.
// Backpressure: req_ready = !full; removes hold the queue head until their road is green.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_op/req_plate request payload
//   green_a, green_b       light state from the simulator
//   disp_req               show display mode (3'b100) while idle
//   mode, plateIn, action  registered simulator command outputs
//   busy                   FSM active or requests queued
//   issued_cnt             fired command count, wraps at 256
module intersection_cmd_driver #(
   parameter int DEPTH   = 4,
   parameter int PLATE_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [PLATE_W-1:0] req_plate,
   input  logic               green_a,
   input  logic               green_b,
   input  logic               disp_req,
   output logic [2:0]         mode,
   output logic [PLATE_W-1:0] plateIn,
   output logic               action,
   output logic               busy,
   output logic [7:0]         issued_cnt
);

   import intersection_cmd_driver_pkg::*;

   state_t               state;
   state_t               next_state;
   logic [PLATE_W+1:0]   head_dat;
   logic [1:0]           head_op;
   logic [PLATE_W-1:0]   head_plate;
   logic                 head_vld;
   logic                 head_green;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [2:0]           mode_n;
   logic [PLATE_W-1:0]   plate_n;
   logic                 action_n;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (PLATE_W + 2)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (req_valid),
      .push_dat ({req_op, req_plate}),
      .pop      (state == ST_RELEASE),
      .head_dat (head_dat),
      .head_vld (head_vld),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_op    = head_dat[PLATE_W+1:PLATE_W];
   assign head_plate = head_dat[PLATE_W-1:0];
   assign head_green = road_green(head_op, green_a, green_b);
   assign req_ready  = !fifo_full;
   assign busy       = (state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Outputs are registered from the state being entered, so each state's
   // outputs are visible for exactly the cycles that state is occupied.
   always_comb begin
      next_state = state;
      mode_n     = mode;
      plate_n    = plateIn;
      action_n   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (head_vld) next_state = head_green ? ST_SETUP : ST_WAIT_GREEN;
         end
         ST_WAIT_GREEN: begin
            if (head_green) next_state = ST_SETUP;
         end
         // Green is re-checked during SETUP; a drop here sends a remove back to wait.
         ST_SETUP:   next_state = head_green ? ST_FIRE : ST_WAIT_GREEN;
         // Once fired, a command always completes regardless of the light.
         ST_FIRE:    next_state = ST_RELEASE;
         ST_RELEASE: next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase

      case (next_state)
         ST_IDLE:       mode_n = disp_req ? MODE_DISPLAY : MODE_BLANK;
         ST_WAIT_GREEN: mode_n = MODE_DISPLAY;
         ST_SETUP: begin
            mode_n = {1'b0, head_op};
            if (is_add(head_op)) plate_n = head_plate;
         end
         ST_FIRE:       action_n = 1'b1;
         default:       ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode       <= MODE_DISPLAY;
         plateIn    <= '0;
         action     <= 1'b0;
         issued_cnt <= 8'd0;
      end else begin
         mode    <= mode_n;
         plateIn <= plate_n;
         action  <= action_n;
         if (next_state == ST_FIRE) issued_cnt <= issued_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_intersection_cmd_driver.sv
module tb_intersection_cmd_driver;

   localparam int DEPTH = 4;
   localparam int PW    = 5;
   localparam int MAXC  = 1100;
   localparam int MARKN = 1400;
   localparam int MAXI  = 300;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [PW-1:0] req_plate = '0;
   logic          green_a = 1'b0;
   logic          green_b = 1'b0;
   logic          disp_req = 1'b0;
   logic [2:0]    mode;
   logic [PW-1:0] plate_in;
   logic          action;
   logic          busy;
   logic [7:0]    issued_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus: list of requests (held until accepted) and per-cycle inputs.
   logic [1:0]    it_op [MAXI];
   logic [PW-1:0] it_pl [MAXI];
   int            nitems;
   bit            gate  [MAXC];
   bit            s_dr  [MAXC];
   bit            s_ga  [MARKN];
   bit            s_gb  [MARKN];

   // Derived drive values and expectations from the reference model.
   bit            d_vld [MAXC];
   logic [1:0]    d_op  [MAXC];
   logic [PW-1:0] d_pl  [MAXC];
   int            e_cnt [MAXC];
   int            kind  [MARKN];  // 0 idle, 1 waiting for green, 2 command on the bus
   logic [1:0]    mop   [MARKN];
   int            pset  [MARKN];  // plate latched this cycle, -1 if none
   bit            act   [MARKN];
   int            accn  [MARKN];
   int            popn  [MARKN];

   intersection_cmd_driver #(.DEPTH(DEPTH), .PLATE_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_plate  (req_plate),
      .green_a    (green_a),
      .green_b    (green_b),
      .disp_req   (disp_req),
      .mode       (mode),
      .plateIn    (plate_in),
      .action     (action),
      .busy       (busy),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit road_ok(input logic [1:0] op, input int c);
      if (op[1]) return 1'b1;
      if (c >= MARKN) return 1'b1;
      return op[0] ? s_gb[c] : s_ga[c];
   endfunction

   task automatic mark(input int i, input int k, input logic [1:0] op);
      if (i < MARKN) begin
         kind[i] = k;
         mop[i]  = op;
      end
   endtask

   // Timeline of one request accepted at edge a, given the engine is free from cycle f.
   // Evaluation starts the cycle after acceptance; a remove needs green on the cycle
   // it is picked up and again on the following (setup) cycle.
   task automatic plan_cmd(input int k, input int a, inout int f);
      int s, c, st;
      logic [1:0] op;
      op = it_op[k];
      s  = (a + 1 > f) ? a + 1 : f;
      c  = s;
      forever begin
         while (!road_ok(op, c)) begin
            if (c > s) mark(c, 1, op);
            c++;
         end
         if (c > s) mark(c, 1, op);
         if (road_ok(op, c + 1)) break;
         mark(c + 1, 2, op);
         c = c + 2;
      end
      st = c + 1;
      for (int i = 0; i < 3; i++) mark(st + i, 2, op);
      if (st + 1 < MARKN) act[st + 1] = 1'b1;
      if (op[1] && st < MARKN) pset[st] = int'(it_pl[k]);
      f = st + 3;
      if (f < MARKN) popn[f]++;
   endtask

   task automatic build_model(input int ncyc);
      int k, cnt, f;
      k = 0; cnt = 0; f = 0;
      for (int i = 0; i < MARKN; i++) begin
         kind[i] = 0; mop[i] = 2'b00; pset[i] = -1; act[i] = 1'b0; accn[i] = 0; popn[i] = 0;
      end
      for (int i = ncyc; i < MARKN; i++) begin
         s_ga[i] = 1'b1;
         s_gb[i] = 1'b1;
      end
      for (int n = 0; n < ncyc; n++) begin
         cnt      = cnt + accn[n] - popn[n];
         e_cnt[n] = cnt;
         d_op[n]  = (k < nitems) ? it_op[k] : 2'b00;
         d_pl[n]  = (k < nitems) ? it_pl[k] : '0;
         d_vld[n] = gate[n] && (k < nitems);
         if (d_vld[n] && cnt < DEPTH) begin
            accn[n + 1]++;
            plan_cmd(k, n + 1, f);
            k++;
         end
      end
   endtask

   task automatic clear_stim(input int ncyc);
      for (int n = 0; n < ncyc; n++) begin
         gate[n] = 1'b1; s_dr[n] = 1'b0; s_ga[n] = 1'b0; s_gb[n] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; green_a = 1'b0; green_b = 1'b0; disp_req = 1'b0;
      @(negedge clk);
      chk("rst_mode",   mode, 3'b100);
      chk("rst_plate",  plate_in, 0);
      chk("rst_action", action, 0);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_ready",  req_ready, 1);
      chk("rst_busy",   busy, 0);
      rst = 1'b0;
   endtask

   task automatic run_scn(input string name, input int ncyc);
      int plate_e, iss_e;
      logic [2:0] mode_e;
      build_model(ncyc);
      do_reset();
      plate_e = 0; iss_e = 0;
      for (int n = 0; n < ncyc; n++) begin
         req_valid = d_vld[n]; req_op = d_op[n]; req_plate = d_pl[n];
         green_a = s_ga[n]; green_b = s_gb[n]; disp_req = s_dr[n];
         if (pset[n] >= 0) plate_e = pset[n];
         if (act[n]) iss_e = (iss_e + 1) % 256;
         if (kind[n] == 1)      mode_e = 3'b100;
         else if (kind[n] == 2) mode_e = {1'b0, mop[n]};
         else if (n == 0)       mode_e = 3'b100;
         else                   mode_e = s_dr[n-1] ? 3'b100 : 3'b000;
         chk($sformatf("%s_mode@%0d", name, n),   mode, mode_e);
         chk($sformatf("%s_plate@%0d", name, n),  plate_in, plate_e);
         chk($sformatf("%s_action@%0d", name, n), action, act[n]);
         chk($sformatf("%s_issued@%0d", name, n), issued_cnt, iss_e);
         chk($sformatf("%s_ready@%0d", name, n),  req_ready, e_cnt[n] < DEPTH);
         chk($sformatf("%s_busy@%0d", name, n),   busy, e_cnt[n] > 0);
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic gen_random(input int ncyc, input int ni);
      bit ga, gb, dr;
      ga = 1'b0; gb = 1'b1; dr = 1'b0;
      nitems = ni;
      for (int k = 0; k < ni; k++) begin
         it_op[k] = 2'($urandom_range(0, 3));
         it_pl[k] = PW'($urandom_range(0, 31));
      end
      for (int n = 0; n < ncyc; n++) begin
         gate[n] = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 5) == 0) ga = !ga;
         if ($urandom_range(0, 5) == 0) gb = !gb;
         if ($urandom_range(0, 7) == 0) dr = !dr;
         s_ga[n] = ga; s_gb[n] = gb; s_dr[n] = dr;
      end
   endtask

   task automatic rst_mid_fire();
      do_reset();
      req_valid = 1'b1; req_op = 2'b10; req_plate = 5'd7;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("r5_pre_action", action, 1);
      chk("r5_pre_issued", issued_cnt, 1);
      rst = 1'b1;
      #1;
      chk("r5_action", action, 0);
      chk("r5_mode",   mode, 3'b100);
      chk("r5_busy",   busy, 0);
      chk("r5_ready",  req_ready, 1);
      chk("r5_issued", issued_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin @(posedge clk); @(negedge clk); end
      chk("r5_post_issued", issued_cnt, 0);
      chk("r5_post_busy",   busy, 0);
      chk("r5_post_mode",   mode, 3'b000);
   endtask

   initial begin
      // 1: single addB, plate 5
      clear_stim(14);
      nitems = 1; it_op[0] = 2'b11; it_pl[0] = 5'd5;
      run_scn("s1", 14);
      chk("s1_final_issued", issued_cnt, 1);

      // 2: remA waits ~20 cycles for green_a
      clear_stim(40);
      nitems = 1; it_op[0] = 2'b00; it_pl[0] = 5'd9;
      for (int n = 22; n < 40; n++) s_ga[n] = 1'b1;
      run_scn("s2", 40);
      chk("s2_final_issued", issued_cnt, 1);

      // 3: green_a drops during SETUP, returns later
      clear_stim(30);
      nitems = 1; it_op[0] = 2'b00; it_pl[0] = 5'd3;
      for (int n = 0; n < 30; n++) s_ga[n] = (n < 3) || (n >= 13);
      run_scn("s3", 30);
      chk("s3_final_issued", issued_cnt, 1);

      // 4: six back-to-back addA, plates 2..12, overruns the FIFO
      clear_stim(40);
      nitems = 6;
      for (int k = 0; k < 6; k++) begin it_op[k] = 2'b10; it_pl[k] = PW'(2 * (k + 1)); end
      run_scn("s4", 40);
      chk("s4_final_issued", issued_cnt, 6);

      // 5: reset during FIRE
      rst_mid_fire();

      // 6: 256 adds wrap issued_cnt; disp_req held high while idle
      clear_stim(1040);
      nitems = 256;
      for (int k = 0; k < 256; k++) begin it_op[k] = 2'b10; it_pl[k] = PW'(k % 32); end
      for (int n = 0; n < 1040; n++) s_dr[n] = 1'b1;
      run_scn("s6", 1040);
      chk("s6_wrap_issued", issued_cnt, 0);
      chk("s6_idle_mode",   mode, 3'b100);

      // Randomized traffic
      for (int r = 0; r < 3; r++) begin
         gen_random(400, 50);
         run_scn($sformatf("rnd%0d", r), 400);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
